decode_stage: RTL and testbench

Instruction-decode stage of the pipelined RISC-V core. It accepts one fetched instruction per cycle from the fetch stage and drives the register-file read addresses. It bypasses a same-cycle register-file write to the operands, decodes the immediate, and detects load-use hazards. It then registers the operands and control into the ID/EX pipeline register, with a valid/ready handshake on both sides and a flush input from the branch-resolution logic.

---
 rtl/riscv_pkg.sv | 91 +++++++++
 rtl/decode_stage_if.sv | 38 +++
 rtl/decode_stage_imm_gen.sv | 30 +++
 rtl/decode_stage.sv | 111 +++++++++++
 tb/tb_decode_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the decode stage of the pipelined RV32 core.
//   - XLEN and the base-ISA major opcodes used by decode
//   - imm_type_e: which immediate format an instruction carries
//   - decode_ctrl_t: per-instruction control derived from the opcode
//   - decode_ctrl(): opcode/rd -> control, shared by the top and anything else that decodes
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  typedef struct packed {
    logic      uses_rs1;
    logic      uses_rs2;
    logic      reg_write;
    logic      is_load;
    imm_type_e imm_type;
  } decode_ctrl_t;

  // Control is a function of the opcode and rd only; no operand data is
  // involved, which keeps the hazard path (and so if_ready) off rs*_data.
  function automatic decode_ctrl_t decode_ctrl(input logic [6:0] opcode,
                                               input logic [4:0] rd);
    decode_ctrl_t c;
    c.uses_rs1  = 1'b1;
    c.uses_rs2  = 1'b0;
    c.reg_write = 1'b0;
    c.is_load   = 1'b0;
    c.imm_type  = IMM_NONE;
    case (opcode)
      OP: begin
        c.uses_rs2  = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_IMM: begin
        c.reg_write = 1'b1;
        c.imm_type  = IMM_I;
      end
      LOAD: begin
        c.reg_write = 1'b1;
        c.is_load   = 1'b1;
        c.imm_type  = IMM_I;
      end
      STORE: begin
        c.uses_rs2 = 1'b1;
        c.imm_type = IMM_S;
      end
      BRANCH: begin
        c.uses_rs2 = 1'b1;
        c.imm_type = IMM_B;
      end
      JAL: begin
        c.uses_rs1  = 1'b0;
        c.reg_write = 1'b1;
        c.imm_type  = IMM_J;
      end
      JALR: begin
        c.reg_write = 1'b1;
        c.imm_type  = IMM_I;
      end
      LUI, AUIPC: begin
        c.uses_rs1  = 1'b0;
        c.reg_write = 1'b1;
        c.imm_type  = IMM_U;
      end
      default: ;
    endcase
    // Writes to x0 are architectural no-ops; treating them as non-writing
    // also keeps them out of the load-use comparison.
    if (rd == 5'd0) c.reg_write = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: pipeline handshake bundle around the decode stage.
//   Fetch side : if_valid/if_pc/if_instr toward decode, if_ready back.
//   Execute side: ex_* ID/EX contents and ex_valid toward execute, ex_ready back.
// Modports:
//   slave  - the decode stage (consumes fetch, produces ID/EX)
//   master - the surrounding pipeline (produces fetch, consumes ID/EX)
interface decode_stage_if;
  import riscv_pkg::*;

  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;

  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_instr;
  logic [XLEN-1:0] ex_rs1;
  logic [XLEN-1:0] ex_rs2;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rd;
  logic            ex_reg_write;
  logic            ex_is_load;

  modport slave (
    input  if_valid, if_pc, if_instr, ex_ready,
    output if_ready, ex_valid, ex_pc, ex_instr, ex_rs1, ex_rs2, ex_imm,
           ex_rd, ex_reg_write, ex_is_load
  );

  modport master (
    output if_valid, if_pc, if_instr, ex_ready,
    input  if_ready, ex_valid, ex_pc, ex_instr, ex_rs1, ex_rs2, ex_imm,
           ex_rd, ex_reg_write, ex_is_load
  );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: combinational RV32 immediate extraction.
//   instr    - instruction word
//   imm_type - immediate format selected by decode
//   imm      - sign-extended 32-bit immediate (0 for IMM_NONE)
module imm_gen
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);

  // The opcode field never contributes to an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch.
    imm = '0;
    case (imm_type)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'h000};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction-decode stage of the pipelined RV32 core.
//   clk, rst           - clock, asynchronous active-high reset
//   bus (slave)        - fetch handshake in, ID/EX register out
//   flush              - kill the instruction in decode and in ID/EX
//   rs1_addr/rs2_addr  - register-file read addresses (combinational)
//   rs1_data/rs2_data  - register-file read data (x0 reads 0)
//   wb_write/addr/data - writeback port, bypassed into the operands
// Holds operand bypass, load-use hazard detection and the ID/EX register.
module decode_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  decode_stage_if.slave   bus,
  input  logic            flush,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_write,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            reg_write;
    logic            is_load;
  } id_ex_t;

  id_ex_t          id_ex;
  decode_ctrl_t    ctrl;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            hazard;
  logic            advance;

  assign rs1_addr = bus.if_instr[19:15];
  assign rs2_addr = bus.if_instr[24:20];
  assign ctrl     = decode_ctrl(bus.if_instr[6:0], bus.if_instr[11:7]);

  imm_gen u_imm_gen (
    .instr    (bus.if_instr),
    .imm_type (ctrl.imm_type),
    .imm      (imm)
  );

  // The register file only commits the writeback at the next edge, so an
  // instruction captured on that same edge must take wb_data directly.
  assign op1 = (wb_write && wb_addr == rs1_addr && wb_addr != 5'd0) ? wb_data : rs1_data;
  assign op2 = (wb_write && wb_addr == rs2_addr && wb_addr != 5'd0) ? wb_data : rs2_data;

  // A load result is not available until after execute, so a dependent
  // instruction right behind it must wait one slot.
  assign hazard = id_ex.valid && id_ex.is_load && (id_ex.rd != 5'd0) &&
                  ((ctrl.uses_rs1 && rs1_addr == id_ex.rd) ||
                   (ctrl.uses_rs2 && rs2_addr == id_ex.rd));

  assign advance = !id_ex.valid || bus.ex_ready;

  always_comb begin
    if (rst || flush)                  bus.if_ready = 1'b1;
    else if (!advance)                 bus.if_ready = 1'b0;
    else if (hazard && bus.if_valid)   bus.if_ready = 1'b0;
    else                               bus.if_ready = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the payload is reset as well, not just valid, because the
      // outputs must read as zero out of reset.
      id_ex <= '0;
    end else if (flush) begin
      id_ex.valid <= 1'b0;
    end else if (!advance) begin
      id_ex <= id_ex;
    end else if (hazard && bus.if_valid) begin
      id_ex.valid <= 1'b0;
    end else begin
      id_ex.valid     <= bus.if_valid;
      id_ex.pc        <= bus.if_pc;
      id_ex.instr     <= bus.if_instr;
      id_ex.rs1       <= op1;
      id_ex.rs2       <= op2;
      id_ex.imm       <= imm;
      id_ex.rd        <= ctrl.reg_write ? bus.if_instr[11:7] : 5'd0;
      id_ex.reg_write <= ctrl.reg_write;
      id_ex.is_load   <= ctrl.is_load;
    end
  end

  assign bus.ex_valid     = id_ex.valid;
  assign bus.ex_pc        = id_ex.pc;
  assign bus.ex_instr     = id_ex.instr;
  assign bus.ex_rs1       = id_ex.rs1;
  assign bus.ex_rs2       = id_ex.rs2;
  assign bus.ex_imm       = id_ex.imm;
  assign bus.ex_rd        = id_ex.rd;
  assign bus.ex_reg_write = id_ex.reg_write;
  assign bus.ex_is_load   = id_ex.is_load;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// transaction-level reference model of the ID/EX register.
module tb_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        wb_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] rf [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_if bus ();

  decode_stage dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .flush    (flush),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wb_write (wb_write),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  // Register file: x0 hard-wired to zero, written on the clock edge.
  assign rs1_data = (rs1_addr == 5'd0) ? 32'h0 : rf[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? 32'h0 : rf[rs2_addr];

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, instr, rs1, rs2, imm;
    logic [4:0]  rd;
    logic        rw, ld;
  } ex_t;

  ex_t  m;          // expected ID/EX contents
  logic last_rdy;   // expected if_ready of the last cycle

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(logic [6:0] op, logic [4:0] rd, logic [2:0] f3,
                                        logic [4:0] rs1, logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, OP};
  endfunction
  function automatic logic [31:0] enc_s(logic [4:0] rs1, logic [4:0] rs2, logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], STORE};
  endfunction
  function automatic logic [31:0] enc_b(logic [4:0] rs1, logic [4:0] rs2, logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'd0, imm[4:1], imm[11], BRANCH};
  endfunction
  function automatic logic [31:0] enc_j(logic [4:0] rd, logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
  endfunction
  function automatic logic [31:0] enc_u(logic [6:0] op, logic [4:0] rd, logic [19:0] imm);
    return {imm, rd, op};
  endfunction

  // ---------------- reference model ----------------
  // Immediates rebuilt by weighting each field with integer arithmetic.
  function automatic logic [31:0] ref_imm(logic [31:0] ins);
    int s;
    int v;
    s = ins[31] ? -1 : 0;
    v = 0;
    case (ins[6:0])
      LOAD, OP_IMM, JALR: v = s * 2048 + int'(ins[30:20]);
      STORE:  v = s * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:7]);
      BRANCH: v = s * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      LUI, AUIPC: v = int'(ins[31:12]) * 4096;
      JAL:    v = s * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                  + int'(ins[30:21]) * 2;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] operand(logic [4:0] a);
    if (wb_write && wb_addr == a && a != 5'd0) return wb_data;
    return (a == 5'd0) ? 32'h0 : rf[a];
  endfunction

  function automatic ex_t decode_ref(logic [31:0] ins, logic [31:0] pc);
    ex_t e;
    logic [6:0] op;
    op      = ins[6:0];
    e.valid = 1'b1;
    e.pc    = pc;
    e.instr = ins;
    e.rs1   = operand(ins[19:15]);
    e.rs2   = operand(ins[24:20]);
    e.imm   = ref_imm(ins);
    e.rw    = (op inside {OP, OP_IMM, LOAD, LUI, AUIPC, JAL, JALR}) && ins[11:7] != 5'd0;
    e.rd    = e.rw ? ins[11:7] : 5'd0;
    e.ld    = (op == LOAD);
    return e;
  endfunction

  task automatic check_ex();
    check("ex_valid", bus.ex_valid, m.valid);
    if (m.valid) begin
      check("ex_pc", bus.ex_pc, m.pc);
      check("ex_instr", bus.ex_instr, m.instr);
      check("ex_rs1", bus.ex_rs1, m.rs1);
      check("ex_rs2", bus.ex_rs2, m.rs2);
      check("ex_imm", bus.ex_imm, m.imm);
      check("ex_rd", bus.ex_rd, m.rd);
      check("ex_reg_write", bus.ex_reg_write, m.rw);
      check("ex_is_load", bus.ex_is_load, m.ld);
    end
  endtask

  // One clock: check combinational outputs, predict, clock, check ID/EX.
  task automatic tick();
    ex_t        nxt;
    logic [31:0] ins;
    logic [6:0] op;
    logic       u1, u2, haz, adv, exp_rdy;
    #2;
    ins = bus.if_instr;
    op  = ins[6:0];
    u1  = !(op == LUI || op == AUIPC || op == JAL);
    u2  = (op == OP || op == STORE || op == BRANCH);
    haz = m.valid && m.ld && m.rd != 5'd0 &&
          ((u1 && ins[19:15] == m.rd) || (u2 && ins[24:20] == m.rd));
    adv = !m.valid || bus.ex_ready;
    nxt = m;
    if (flush) begin
      nxt.valid = 1'b0;
      exp_rdy   = 1'b1;
    end else if (!adv) begin
      exp_rdy = 1'b0;
    end else if (haz && bus.if_valid) begin
      nxt.valid = 1'b0;
      exp_rdy   = 1'b0;
    end else begin
      nxt       = decode_ref(ins, bus.if_pc);
      nxt.valid = bus.if_valid;
      exp_rdy   = 1'b1;
    end
    check("if_ready", bus.if_ready, exp_rdy);
    check("rs1_addr", rs1_addr, ins[19:15]);
    check("rs2_addr", rs2_addr, ins[24:20]);
    last_rdy = exp_rdy;
    @(posedge clk);
    if (wb_write && wb_addr != 5'd0) rf[wb_addr] = wb_data;
    m = nxt;
    #1;
    check_ex();
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    bus.if_valid = v;
    bus.if_pc    = pc;
    bus.if_instr = ins;
  endtask

  logic [6:0]  ops [10];
  logic        holding;
  logic [31:0] rpc, rins;
  logic        rvalid;

  initial begin
    ops = '{OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, 7'h7f};
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'h0 : $urandom;
    rst = 1'b1;
    flush = 1'b0;
    wb_write = 1'b0;
    wb_addr = '0;
    wb_data = '0;
    bus.ex_ready = 1'b1;
    offer(1'b0, 32'h0, 32'h0);
    m = '0;
    last_rdy = 1'b1;

    // ---- reset state ----
    #12;
    check("rst_if_ready", bus.if_ready, 1'b1);
    check("rst_ex_valid", bus.ex_valid, 1'b0);
    check("rst_ex_pc", bus.ex_pc, 32'h0);
    check("rst_ex_instr", bus.ex_instr, 32'h0);
    check("rst_ex_rs1", bus.ex_rs1, 32'h0);
    check("rst_ex_rs2", bus.ex_rs2, 32'h0);
    check("rst_ex_imm", bus.ex_imm, 32'h0);
    check("rst_ex_rd", bus.ex_rd, 32'h0);
    check("rst_ex_reg_write", bus.ex_reg_write, 1'b0);
    check("rst_ex_is_load", bus.ex_is_load, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ---- back-to-back addi ----
    offer(1'b1, 32'h100, enc_i(OP_IMM, 5'd1, 3'd0, 5'd0, 12'd5));
    tick();
    check("addi1_valid", bus.ex_valid, 1'b1);
    check("addi1_imm", bus.ex_imm, 32'd5);
    check("addi1_rd", bus.ex_rd, 32'd1);
    offer(1'b1, 32'h104, enc_i(OP_IMM, 5'd2, 3'd0, 5'd0, 12'd7));
    tick();
    check("addi2_valid", bus.ex_valid, 1'b1);
    check("addi2_imm", bus.ex_imm, 32'd7);
    check("addi2_rd", bus.ex_rd, 32'd2);

    // ---- load-use: one bubble ----
    offer(1'b1, 32'h108, enc_i(LOAD, 5'd5, 3'd2, 5'd1, 12'd0));
    tick();
    check("lw_is_load", bus.ex_is_load, 1'b1);
    offer(1'b1, 32'h10c, enc_r(5'd6, 5'd5, 5'd2));
    tick();
    check("lu_stall_ready", last_rdy, 1'b0);
    check("lu_bubble", bus.ex_valid, 1'b0);
    tick();
    check("lu_issue_valid", bus.ex_valid, 1'b1);
    check("lu_issue_pc", bus.ex_pc, 32'h10c);
    // independent add after load: no bubble
    offer(1'b1, 32'h110, enc_i(LOAD, 5'd5, 3'd2, 5'd1, 12'd0));
    tick();
    offer(1'b1, 32'h114, enc_r(5'd6, 5'd1, 5'd2));
    tick();
    check("nohaz_valid", bus.ex_valid, 1'b1);
    check("nohaz_pc", bus.ex_pc, 32'h114);

    // ---- backpressure for three cycles ----
    offer(1'b1, 32'h118, enc_i(OP_IMM, 5'd3, 3'd0, 5'd0, 12'd9));
    tick();
    bus.ex_ready = 1'b0;
    offer(1'b1, 32'h11c, enc_i(OP_IMM, 5'd4, 3'd0, 5'd0, 12'd11));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_pc", bus.ex_pc, 32'h118);
      check("bp_hold_imm", bus.ex_imm, 32'd9);
    end
    bus.ex_ready = 1'b1;
    tick();
    check("bp_resume_pc", bus.ex_pc, 32'h11c);
    offer(1'b0, 32'h120, 32'h0);
    tick();
    check("bp_no_dup", bus.ex_valid, 1'b0);

    // ---- writeback bypass ----
    rf[3] = 32'h0;
    wb_write = 1'b1;
    wb_addr  = 5'd3;
    wb_data  = 32'hDEADBEEF;
    offer(1'b1, 32'h120, enc_r(5'd4, 5'd3, 5'd3));
    tick();
    check("byp_rs1", bus.ex_rs1, 32'hDEADBEEF);
    check("byp_rs2", bus.ex_rs2, 32'hDEADBEEF);
    wb_addr = 5'd0;
    offer(1'b1, 32'h124, enc_r(5'd4, 5'd0, 5'd0));
    tick();
    check("byp_x0_rs1", bus.ex_rs1, 32'h0);
    check("byp_x0_rs2", bus.ex_rs2, 32'h0);
    wb_write = 1'b0;

    // ---- flush during a load-use stall ----
    offer(1'b1, 32'h128, enc_i(LOAD, 5'd5, 3'd2, 5'd1, 12'd0));
    tick();
    offer(1'b1, 32'h12c, enc_r(5'd6, 5'd5, 5'd2));
    flush = 1'b1;
    tick();
    check("fl_ready", last_rdy, 1'b1);
    check("fl_valid", bus.ex_valid, 1'b0);
    flush = 1'b0;
    offer(1'b1, 32'h130, enc_i(OP_IMM, 5'd7, 3'd0, 5'd0, 12'd1));
    tick();
    check("fl_next_pc", bus.ex_pc, 32'h130);
    check("fl_next_rd", bus.ex_rd, 32'd7);

    // ---- immediate formats ----
    offer(1'b1, 32'h134, enc_b(5'd1, 5'd2, 13'h1FFC));
    tick();
    check("imm_beq", bus.ex_imm, 32'hFFFFFFFC);
    check("beq_rd", bus.ex_rd, 32'd0);
    offer(1'b1, 32'h138, enc_j(5'd1, 21'd2048));
    tick();
    check("imm_jal", bus.ex_imm, 32'h00000800);
    offer(1'b1, 32'h13c, enc_u(LUI, 5'd1, 20'hABCDE));
    tick();
    check("imm_lui", bus.ex_imm, 32'hABCDE000);
    offer(1'b1, 32'h140, enc_s(5'd1, 5'd2, 12'hFFF));
    tick();
    check("imm_sw", bus.ex_imm, 32'hFFFFFFFF);

    // ---- reset while a load is held ----
    offer(1'b1, 32'h144, enc_i(LOAD, 5'd5, 3'd2, 5'd1, 12'd0));
    tick();
    bus.ex_ready = 1'b0;
    offer(1'b1, 32'h148, enc_r(5'd6, 5'd5, 5'd2));
    tick();
    #1;
    rst = 1'b1;
    #1;
    check("mrst_ex_valid", bus.ex_valid, 1'b0);
    check("mrst_ex_rd", bus.ex_rd, 32'd0);
    check("mrst_if_ready", bus.if_ready, 1'b1);
    m = '0;
    offer(1'b0, 32'h0, 32'h0);
    bus.ex_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_after", bus.ex_valid, 1'b0);

    // ---- randomized traffic against the model ----
    holding = 1'b0;
    rpc     = 32'h1000;
    rins    = 32'h0;
    rvalid  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!holding) begin
        rins        = $urandom;
        rins[6:0]   = ops[$urandom_range(0, 9)];
        rins[11:7]  = 5'($urandom_range(0, 7));
        rins[19:15] = 5'($urandom_range(0, 7));
        rins[24:20] = 5'($urandom_range(0, 7));
        rpc         = rpc + 32'd4;
        rvalid      = ($urandom_range(0, 9) < 8);
      end
      offer(rvalid, rpc, rins);
      bus.ex_ready = ($urandom_range(0, 9) < 7);
      flush        = ($urandom_range(0, 19) == 0);
      wb_write     = 1'($urandom_range(0, 1));
      wb_addr      = 5'($urandom_range(0, 7));
      wb_data      = $urandom;
      tick();
      holding = rvalid && !last_rdy;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
